// File: rtl/pdu_dbg.sv
// ---------------------------------------------------------------------------
// pdu_dbg -- processor debug unit for the pipelined CPU.
//
// Sits between the board IO (switches, buttons, LEDs, scanned 7-segment
// display) and the CPU core. It:
//   * generates the CPU clock, either free-running (half the board clock)
//     or one pulse per step-button press;
//   * serves the CPU's memory-mapped IO bus (LED/display registers, switch
//     and status readback);
//   * multiplexes the IO result, register file, data memory and NCH pipeline
//     debug channels onto the LEDs and the scanned hex display.
//
// Optional feature, build macro PDU_DBG_BREAKPOINT_EN:
//   defined   -> PC breakpoint (bp_addr at IO 0x14, bp_en at IO 0x18); a hit
//                parks the CPU clock low in HALT; status bit1 reports HALT.
//   undefined -> no breakpoint registers, HALT unreachable, writes to
//                0x14/0x18 ignored, status bit1 reads 0.
//
// Parameters
//   DW      data width of IO bus, debug data and display word (= 4*DIGITS)
//   NCH     number of pipeline debug channels (2..32)
//   DIGITS  number of scanned hex digits
//   REF_W   display refresh counter width
//
// Ports
//   clk, rst          board clock, synchronous active-high reset
//   run, step         free-run level / single-step button
//   clk_cpu           registered CPU clock
//   valid             view-cycle switch (both edges count)
//   in[4:0]           in[0] next, in[1] pre (both edges), in[4:2] memory page
//   check[1:0]        current view: 00 IO, 01 reg file, 10 memory, 11 channel
//   out0[4:0], ready  LEDs: index/result and ready flag
//   an, seg           selected digit and its hex nibble
//   io_addr/io_dout/io_we/io_din   CPU IO bus (write registered, read comb.)
//   m_rf_addr         reg-file / memory debug read address
//   rf_data, m_data   debug read data
//   pc                IF-stage PC (breakpoint compare)
//   dbg_data          flattened channels, channel k = bits [k*DW +: DW]
// ---------------------------------------------------------------------------
module pdu_dbg #(
  parameter int DW     = 32,
  parameter int NCH    = 16,
  parameter int DIGITS = 8,
  parameter int REF_W  = 13
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic                        step,
  output logic                        clk_cpu,
  input  logic                        valid,
  input  logic [4:0]                  in,
  output logic [1:0]                  check,
  output logic [4:0]                  out0,
  output logic                        ready,
  output logic [$clog2(DIGITS)-1:0]   an,
  output logic [3:0]                  seg,
  input  logic [7:0]                  io_addr,
  input  logic [DW-1:0]               io_dout,
  input  logic                        io_we,
  output logic [DW-1:0]               io_din,
  output logic [7:0]                  m_rf_addr,
  input  logic [DW-1:0]               rf_data,
  input  logic [DW-1:0]               m_data,
  input  logic [DW-1:0]               pc,
  input  logic [NCH*DW-1:0]           dbg_data
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AN_W = $clog2(DIGITS);

  localparam logic [CH_W-1:0] CH_MAX = CH_W'(NCH - 1);

  // Clock generator states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  // IO register map
  localparam logic [7:0] A_OUT0   = 8'h00;
  localparam logic [7:0] A_READY  = 8'h04;
  localparam logic [7:0] A_OUT1   = 8'h08;
  localparam logic [7:0] A_IN     = 8'h0C;
  localparam logic [7:0] A_VALID  = 8'h10;
  localparam logic [7:0] A_BPADDR = 8'h14;
  localparam logic [7:0] A_BPEN   = 8'h18;
  localparam logic [7:0] A_STATUS = 8'h1C;

  // -------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // -------------------------------------------------------------------------
  logic       r_run_r;
  logic       r_step_r, r_step_2r;
  logic       r_valid_r, r_valid_2r;
  logic [4:0] r_in_r;
  logic [1:0] r_in_2r;

  // Edge pulses are registered so that every button/switch reaches its
  // consumer (counters, view select, CPU clock) exactly 3 clk after the edge.
  logic r_step_p;
  logic r_valid_pn;
  logic r_next_pn;
  logic r_pre_pn;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_r    <= 1'b0;
      r_step_r   <= 1'b0;
      r_step_2r  <= 1'b0;
      r_valid_r  <= 1'b0;
      r_valid_2r <= 1'b0;
      r_in_r     <= 5'd0;
      r_in_2r    <= 2'd0;
      r_step_p   <= 1'b0;
      r_valid_pn <= 1'b0;
      r_next_pn  <= 1'b0;
      r_pre_pn   <= 1'b0;
    end else begin
      r_run_r    <= run;
      r_step_r   <= step;
      r_step_2r  <= r_step_r;
      r_valid_r  <= valid;
      r_valid_2r <= r_valid_r;
      r_in_r     <= in;
      r_in_2r    <= r_in_r[1:0];
      // step reacts to press only; valid/next/pre react to both edges
      r_step_p   <= r_step_r & ~r_step_2r;
      r_valid_pn <= r_valid_r ^ r_valid_2r;
      r_next_pn  <= r_in_r[0] ^ r_in_2r[0];
      r_pre_pn   <= r_in_r[1] ^ r_in_2r[1];
    end
  end

  // -------------------------------------------------------------------------
  // IO write registers (and optional breakpoint registers)
  // -------------------------------------------------------------------------
  logic [4:0]    r_out0;
  logic          r_ready;
  logic [DW-1:0] r_out1;
  logic          w_bp_hit;
  logic          w_halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out0  <= 5'h1f;
      r_ready <= 1'b1;
      r_out1  <= DW'(32'h1234_5678);
    end else if (io_we) begin
      case (io_addr)
        A_OUT0:  r_out0  <= io_dout[4:0];
        A_READY: r_ready <= io_dout[0];
        A_OUT1:  r_out1  <= io_dout;
        default: ;
      endcase
    end
  end

`ifdef PDU_DBG_BREAKPOINT_EN
  logic [DW-1:0] r_bp_addr;
  logic          r_bp_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bp_addr <= '0;
      r_bp_en   <= 1'b0;
    end else if (io_we) begin
      if (io_addr == A_BPADDR) r_bp_addr <= io_dout;
      if (io_addr == A_BPEN)   r_bp_en   <= io_dout[0];
    end
  end
`endif

  // -------------------------------------------------------------------------
  // CPU clock generator
  // -------------------------------------------------------------------------
  logic [1:0] r_state;
  logic       r_clk_cpu;

`ifdef PDU_DBG_BREAKPOINT_EN
  // Compare only while the CPU clock is low, i.e. just before the rising
  // edge that would latch the instruction at bp_addr into IF/ID.
  assign w_bp_hit = (r_state == S_RUN) && !r_clk_cpu && r_bp_en &&
                    (pc == r_bp_addr);
  assign w_halted = (r_state == S_HALT);
`else
  logic w_unused_pc;
  assign w_unused_pc = ^pc;
  assign w_bp_hit    = 1'b0;
  assign w_halted    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_clk_cpu <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // single-step: one board-clock-wide pulse per press
          r_clk_cpu <= r_step_p;
          if (r_run_r) r_state <= S_RUN;
        end
        S_RUN: begin
          if (!r_run_r) begin
            r_state   <= S_IDLE;
            r_clk_cpu <= 1'b0;
          end else if (w_bp_hit) begin
            r_state   <= S_HALT;
            r_clk_cpu <= 1'b0;
          end else begin
            r_clk_cpu <= ~r_clk_cpu;
          end
        end
        S_HALT: begin
          // parked until run is released; step has no effect here
          r_clk_cpu <= 1'b0;
          if (!r_run_r) r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_clk_cpu <= 1'b0;
        end
      endcase
    end
  end

  assign clk_cpu = r_clk_cpu;

  // -------------------------------------------------------------------------
  // View select, index and channel counters
  // -------------------------------------------------------------------------
  logic [1:0]      r_check;
  logic [4:0]      r_idx;
  logic [CH_W-1:0] r_ch;
  logic            w_ch_view;

  assign w_ch_view = (r_check == 2'b11);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_check <= 2'b00;
    end else if (r_run_r || r_step_p) begin
      // running or stepping always shows the IO result view
      r_check <= 2'b00;
    end else if (r_valid_pn) begin
      r_check <= r_check - 2'b01;
    end
  end

  // idx wraps naturally mod 32; next wins over pre
  always_ff @(posedge clk) begin
    if (rst || r_step_p) begin
      r_idx <= 5'd0;
    end else if (!w_ch_view) begin
      if (r_next_pn)     r_idx <= r_idx + 5'd1;
      else if (r_pre_pn) r_idx <= r_idx - 5'd1;
    end
  end

  // ch wraps explicitly since NCH need not be a power of two
  always_ff @(posedge clk) begin
    if (rst || r_step_p) begin
      r_ch <= '0;
    end else if (w_ch_view) begin
      if (r_next_pn)     r_ch <= (r_ch == CH_MAX) ? '0 : r_ch + CH_W'(1);
      else if (r_pre_pn) r_ch <= (r_ch == '0) ? CH_MAX : r_ch - CH_W'(1);
    end
  end

  assign check     = r_check;
  assign m_rf_addr = r_check[1] ? {r_in_r[4:2], r_idx} : {3'b000, r_idx};

  // -------------------------------------------------------------------------
  // Display multiplexing
  // -------------------------------------------------------------------------
  logic [DW-1:0] w_chan [NCH];
  logic [DW-1:0] w_disp;
  logic [4:0]    w_out0;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign w_chan[gi] = dbg_data[gi*DW +: DW];
    end
  endgenerate

  always_comb begin
    w_disp = r_out1;
    w_out0 = r_out0;
    case (r_check)
      2'b01: begin
        w_out0 = r_idx;
        w_disp = rf_data;
      end
      2'b10: begin
        w_out0 = r_idx;
        w_disp = m_data;
      end
      2'b11: begin
        w_out0 = 5'(r_ch);
        w_disp = w_chan[r_ch];
      end
      default: begin
        w_out0 = r_out0;
        w_disp = r_out1;
      end
    endcase
  end

  assign out0  = w_out0;
  assign ready = r_ready;

  // -------------------------------------------------------------------------
  // Scanned display: free-running refresh counter, top bits pick the digit
  // -------------------------------------------------------------------------
  logic [REF_W-1:0] r_refresh;
  logic [3:0]       w_nib [DIGITS];

  always_ff @(posedge clk) begin
    if (rst) r_refresh <= '0;
    else     r_refresh <= r_refresh + REF_W'(1);
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign w_nib[gi] = w_disp[gi*4 +: 4];
    end
  endgenerate

  assign an  = r_refresh[REF_W-1 -: AN_W];
  assign seg = w_nib[an];

  // -------------------------------------------------------------------------
  // IO read mux (combinational)
  // -------------------------------------------------------------------------
  always_comb begin
    io_din = '0;
    case (io_addr)
      A_IN:     io_din = DW'(r_in_r);
      A_VALID:  io_din = DW'(r_valid_r);
      A_STATUS: io_din = DW'({w_halted, (r_state == S_RUN)});
      default:  io_din = '0;
    endcase
  end

endmodule
